// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared constants and helpers for the booth multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  localparam int DEFAULT_SIZE = 5;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker, searching upward from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int  N  = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = PW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_arbiter
// Description : Round-robin sharing of one booth multiplier among NREQ clients.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_arbiter
  import booth_pkg::*;
#(
  parameter int  SIZE    = DEFAULT_SIZE,
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 4*(2**SIZE)+8,
  localparam int W       = 2**SIZE,
  localparam int IDW     = clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_mcand,
  input  logic [NREQ*W-1:0]   req_mplier,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_product,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [W-1:0]        mul_mcand,
  output logic [W-1:0]        mul_mplier,
  input  logic [2*W-1:0]      mul_product,
  input  logic                mul_done,
  output logic                busy
);

  localparam int CW = clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_LAUNCH  = S_LAUNCH,
    ST_WAIT    = S_WAIT,
    ST_RESPOND = S_RESPOND
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] w_gnt_onehot;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req        (req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    err_d     = err_q;
    req_ready = '0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Suppress the grant during reset so no client sees a handshake that gets dropped.
        if (w_any && !rst) begin
          req_ready = w_gnt_onehot;
          id_d      = w_gnt_idx;
          mcand_d   = req_mcand[w_gnt_idx*W +: W];
          mplier_d  = req_mplier[w_gnt_idx*W +: W];
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_q == 0 marks the first WAIT cycle, where done may still belong to the prior op.
        if (cnt_q != '0 && mul_done) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid   = (state_q == ST_RESPOND);
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;
  assign mul_mcand   = mcand_q;
  assign mul_mplier  = mplier_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_arbiter
// Description : Self-checking bench for booth_arbiter with a behavioural booth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_arbiter;
  import booth_pkg::*;

  localparam int SIZE    = 5;
  localparam int NREQ    = 4;
  localparam int W       = 2**SIZE;
  localparam int TIMEOUT = 4*W + 8;
  localparam int IDW     = clog2(NREQ);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*W-1:0]   req_mcand, req_mplier;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_product;
  logic                rsp_err;
  logic                mul_start;
  logic [W-1:0]        mul_mcand, mul_mplier;
  logic [2*W-1:0]      mul_product;
  logic                mul_done;
  logic                busy;

  booth_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mcand(req_mcand), .req_mplier(req_mplier),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
    .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
  );

  // Per-requester operands, packed onto the flattened buses.
  logic [W-1:0]    opa [NREQ];
  logic [W-1:0]    opb [NREQ];
  logic [NREQ-1:0] reload;

  always_comb begin
    req_mcand  = '0;
    req_mplier = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_mcand[i*W +: W]  = opa[i];
      req_mplier[i*W +: W] = opb[i];
    end
  end

  // Behavioural booth: done rises bm_lat cycles after the start edge and stays
  // high until the next start. stale_mode also raises done, with a garbage
  // product, in the first cycle after start; never_done suppresses completion.
  int           bm_lat     = 3;
  bit           never_done = 1'b0;
  bit           stale_mode = 1'b0;
  logic         bm_run     = 1'b0;
  int           bm_k       = 0;
  int           bm_lat_q   = 1;
  logic [W-1:0] bm_a       = '0;
  logic [W-1:0] bm_b       = '0;
  logic signed [2*W-1:0] bm_ax, bm_bx;

  always @(posedge clk) begin
    if (rst) begin
      bm_run <= 1'b0;
      bm_k   <= 0;
    end else if (mul_start) begin
      bm_run   <= 1'b1;
      bm_k     <= 0;
      bm_a     <= mul_mcand;
      bm_b     <= mul_mplier;
      bm_lat_q <= bm_lat;
    end else if (bm_run) begin
      bm_k <= bm_k + 1;
    end
  end

  always_comb begin
    bm_ax       = {{W{bm_a[W-1]}}, bm_a};
    bm_bx       = {{W{bm_b[W-1]}}, bm_b};
    mul_done    = bm_run && ((stale_mode && bm_k == 0) || (!never_done && bm_k >= bm_lat_q));
    mul_product = (bm_run && bm_k >= bm_lat_q) ? bm_ax * bm_bx : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Reference model state
  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
    bit             err;
  } exp_t;

  exp_t exp_q[$];
  int   gq[$];
  int   ptr_m;
  int   n_pass, n_fail, n_total;
  int   n_starts, n_rsp, cyc, start_cyc, rsp_rise_cyc;
  bit   rsp_prev;
  int   last_id;
  logic [2*W-1:0] last_prod;
  bit   last_err;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, let the edge occur, then update requesters.
  task automatic tick();
    logic [NREQ-1:0] hs;
    bit   rhs;
    bit   in_rst;
    int   g;
    exp_t x;
    @(negedge clk);
    cyc++;
    in_rst = rst;
    hs     = req_valid & req_ready;
    rhs    = rsp_valid && rsp_ready;
    if (mul_start) begin
      n_starts++;
      start_cyc = cyc;
    end
    if (rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
    rsp_prev = rsp_valid;
    if (!in_rst && hs != '0) begin
      chk("ready_onehot", 128'($countones(req_ready)), 128'(1));
      g = 0;
      for (int i = 0; i < NREQ; i++) if (hs[i]) g = i;
      chk("grant_idx", 128'(g), 128'(rr_pick(req_valid, ptr_m)));
      gq.push_back(g);
      x.id   = g;
      x.err  = never_done;
      x.prod = never_done ? '0 : ref_mul(opa[g], opb[g]);
      exp_q.push_back(x);
    end
    if (!in_rst && rhs) begin
      chk("rsp_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("rsp_id", 128'(rsp_id), 128'(x.id));
        chk("rsp_product", 128'(rsp_product), 128'(x.prod));
        chk("rsp_err", 128'(rsp_err), 128'(x.err));
        ptr_m = (x.id + 1) % NREQ;
      end
      last_id   = int'(rsp_id);
      last_prod = rsp_product;
      last_err  = rsp_err;
      n_rsp++;
    end
    @(posedge clk);
    #1;
    if (!in_rst)
      for (int i = 0; i < NREQ; i++)
        if (hs[i]) begin
          if (reload[i]) begin
            opa[i] = rand_op();
            opb[i] = rand_op();
          end else begin
            req_valid[i] = 1'b0;
          end
        end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (n_rsp < target && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_arrived", 128'(n_rsp >= target), 128'(1));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 0;
    exp_q.delete();
    gq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1);
  end

  initial begin
    int n, s0, r0, t;
    int           exp_order [5] = '{0, 1, 2, 3, 0};
    logic [IDW-1:0] h_id;
    logic [2*W-1:0] h_prod;
    logic           h_err;

    n_pass = 0; n_fail = 0; n_total = 0;
    n_starts = 0; n_rsp = 0; cyc = 0; start_cyc = 0; rsp_rise_cyc = 0;
    rsp_prev = 1'b0; ptr_m = 0; last_id = 0; last_prod = '0; last_err = 1'b0;
    req_valid = '0; rsp_ready = 1'b0; reload = '0; rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_mul_start", 128'(mul_start), 128'(0));
    chk("rst_rsp_product", 128'(rsp_product), 128'(0));
    chk("rst_mul_mcand", 128'(mul_mcand), 128'(0));
    rst = 1'b0;

    // 1: single op, -3 * 7 from requester 2
    bm_lat = 3;
    opa[2] = 32'hFFFF_FFFD;
    opb[2] = 32'd7;
    req_valid[2] = 1'b1;
    rsp_ready = 1'b1;
    s0 = n_starts;
    wait_rsp(n_rsp + 1, 50);
    chk("t1_starts", 128'(n_starts - s0), 128'(1));
    chk("t1_id", 128'(last_id), 128'(2));
    chk("t1_product", 128'(last_prod), 128'(64'hFFFF_FFFF_FFFF_FFEB));
    chk("t1_err", 128'(last_err), 128'(0));
    chk("t1_latency", 128'(rsp_rise_cyc - start_cyc), 128'(bm_lat + 2));

    // 2: contention from reset, all requesters continuously valid
    do_reset(2);
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = rand_op();
      opb[i] = rand_op();
    end
    reload = '1;
    req_valid = '1;
    bm_lat = 2;
    wait_rsp(n_rsp + 5, 100);
    req_valid = '0;
    reload = '0;
    chk("t2_grants", 128'(gq.size()), 128'(5));
    for (int k = 0; k < 5 && k < gq.size(); k++)
      chk("t2_order", 128'(gq[k]), 128'(exp_order[k]));

    // 3: backpressure in RESPOND
    opa[1] = rand_op();
    opb[1] = rand_op();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t3_respond", 128'(rsp_valid), 128'(1));
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = rand_op();
      opb[i] = rand_op();
    end
    req_valid = '1;
    h_id = rsp_id; h_prod = rsp_product; h_err = rsp_err;
    s0 = n_starts;
    r0 = n_rsp;
    repeat (20) begin
      tick();
      chk("t3_hold_valid", 128'(rsp_valid), 128'(1));
      chk("t3_hold_id", 128'(rsp_id), 128'(h_id));
      chk("t3_hold_product", 128'(rsp_product), 128'(h_prod));
      chk("t3_hold_err", 128'(rsp_err), 128'(h_err));
      chk("t3_no_ready", 128'(req_ready), 128'(0));
    end
    chk("t3_no_start", 128'(n_starts - s0), 128'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = '0;
    repeat (3) tick();
    chk("t3_one_handshake", 128'(n_rsp - r0), 128'(1));
    chk("t3_idle", 128'(busy), 128'(0));

    // 4: timeout, then a normal op
    never_done = 1'b1;
    rsp_ready = 1'b1;
    opa[3] = rand_op();
    opb[3] = rand_op();
    req_valid = 4'b1000;
    wait_rsp(n_rsp + 1, TIMEOUT + 40);
    chk("t4_wait_cycles", 128'(rsp_rise_cyc - start_cyc), 128'(TIMEOUT + 1));
    chk("t4_err", 128'(last_err), 128'(1));
    chk("t4_product", 128'(last_prod), 128'(0));
    never_done = 1'b0;
    opa[0] = rand_op();
    opb[0] = rand_op();
    req_valid = 4'b0001;
    wait_rsp(n_rsp + 1, 50);
    chk("t4_next_err", 128'(last_err), 128'(0));
    chk("t4_next_id", 128'(last_id), 128'(0));

    // 5: reset in the middle of WAIT
    bm_lat = 30;
    opa[2] = rand_op();
    opb[2] = rand_op();
    req_valid = 4'b0100;
    s0 = n_starts;
    n = 0;
    while (n_starts == s0 && n < 10) begin
      tick();
      n++;
    end
    chk("t5_launched", 128'(n_starts - s0), 128'(1));
    repeat (3) tick();
    chk("t5_in_wait", 128'(busy), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_outputs", 128'({req_ready, rsp_valid, rsp_id, rsp_err, mul_start, busy}), 128'(0));
    chk("t5_rst_product", 128'(rsp_product), 128'(0));
    chk("t5_rst_operands", 128'({mul_mcand, mul_mplier}), 128'(0));
    rst = 1'b0;
    ptr_m = 0;
    exp_q.delete();
    gq.delete();
    r0 = n_rsp;
    repeat (40) tick();
    chk("t5_dropped", 128'(n_rsp - r0), 128'(0));
    bm_lat = 2;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = rand_op();
      opb[i] = rand_op();
    end
    req_valid = '1;
    n = 0;
    while (gq.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    req_valid = '0;
    chk("t5_granted", 128'(gq.size()), 128'(1));
    if (gq.size() != 0) chk("t5_first_grant", 128'(gq[0]), 128'(0));
    wait_rsp(n_rsp + 1, 50);

    // 6: stale done from the previous op
    bm_lat = 4;
    opa[1] = rand_op();
    opb[1] = rand_op();
    req_valid = 4'b0010;
    wait_rsp(n_rsp + 1, 50);
    stale_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bm_lat = (k == 0) ? 4 : 1;
      t = (k == 0) ? 3 : 2;
      opa[t] = rand_op();
      opb[t] = rand_op();
      req_valid[t] = 1'b1;
      wait_rsp(n_rsp + 1, 50);
      chk("t6_latency", 128'(rsp_rise_cyc - start_cyc), 128'(bm_lat + 2));
      chk("t6_id", 128'(last_id), 128'(t));
    end

    // Random traffic with random backpressure and booth latency
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          opa[i] = rand_op();
          opb[i] = rand_op();
          req_valid[i] = 1'b1;
        end
      rsp_ready  = ($urandom_range(2) != 0);
      stale_mode = ($urandom_range(1) != 0);
      bm_lat     = $urandom_range(8, 1);
      tick();
    end
    rsp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy || req_valid != '0) && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_idle", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
